// File: rtl/load_trace_ctl_if.sv
// load_trace_ctl_if: trace record read port between the recorder (master) and a host (slave)
interface load_trace_ctl_if #(
    parameter int REC_W = 1
);
    logic [REC_W-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, valid, input ready);
    modport slave  (input data, valid, output ready);
endinterface

// File: rtl/load_trace_ctl.sv
// load_trace_ctl: 704 card-reader LOAD sequencer, run gate and instruction trace FIFO
module load_trace_ctl #(
    parameter int          NKEYS        = 6,
    parameter int          NXR          = 3,
    parameter int          XR_W         = 13,
    parameter int          IC_W         = 13,
    parameter int          DEPTH        = 16,
    parameter int          KEY_SETTLE   = 4,
    parameter int          LOAD_CYCLES  = 1000,
    parameter int unsigned MAX_INST     = 0,
    parameter int unsigned MAX_CYCLES   = 0,
    parameter bit          STOP_ON_FULL = 1,
    localparam int         REC_W        = IC_W + 38 + 36 + NXR * XR_W + 36
) (
    input  logic                cl,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NKEYS-1:0]    key_mask,
    output logic [NKEYS-1:0]    sense_keys,
    output logic                load_cr,
    output logic                run_en,
    input  logic                prog_stop,
    input  logic                rd_wr_select,
    input  logic                rd_wr_check,
    input  logic                inst,
    input  logic [IC_W-1:0]     ic,
    input  logic [37:0]         ac,
    input  logic [35:0]         mq,
    input  logic [NXR*XR_W-1:0] xr,
    input  logic [35:0]         stg,
    load_trace_ctl_if.master    tr,
    output logic [31:0]         inst_count,
    output logic [15:0]         drops,
    output logic [2:0]          stop_code,
    output logic                busy,
    output logic                done
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, KEYS, LOAD, RUN, HOLD, DONE} state_t;

    state_t           state;
    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] rec, skid;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [31:0]      timer, run_cycles, inst_next;
    logic             skid_valid, skid_next, inst_q;
    logic             empty, full, pop, free, cap, blocked, to_skid, push, accept;
    logic             in_run, lamp, limit, timeout;
    logic [2:0]       code;

    assign rec       = {ic, ac, mq, xr, stg};
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && tr.ready;
    assign free      = !full || pop;
    assign cap       = (state == LOAD || state == RUN || state == HOLD) && inst && !inst_q;
    // A record cannot go straight to the FIFO if an older one waits in the skid or there is no slot
    assign blocked   = skid_valid || !free;
    assign to_skid   = STOP_ON_FULL && cap && blocked && (!skid_valid || free);
    assign skid_next = to_skid || (skid_valid && !free);
    // The skid entry always drains ahead of a fresh capture to keep records in order
    assign push      = skid_valid ? free : cap && free;
    assign accept    = start && (state == IDLE || (state == DONE && empty && !skid_valid));
    assign inst_next = inst_count + 32'(cap);
    assign in_run    = state == RUN || state == HOLD;
    assign lamp      = state == RUN && !rd_wr_select && (prog_stop || rd_wr_check);
    assign limit     = MAX_INST != 0 && in_run && inst_next >= MAX_INST;
    assign timeout   = MAX_CYCLES != 0 && in_run && run_cycles + 32'd1 >= MAX_CYCLES;
    assign code      = (abort && busy) ? 3'd5 : lamp ? (rd_wr_check ? 3'd2 : 3'd1) :
                       limit ? 3'd3 : timeout ? 3'd4 : 3'd0;
    assign busy      = state == KEYS || state == LOAD || state == RUN || state == HOLD;
    assign done      = state == DONE;
    assign tr.valid  = !empty;
    assign tr.data   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Trace storage; contents need no reset because reads are masked while empty
    always_ff @(posedge cl) begin
        if (push) mem[wr_ptr[AW-1:0]] <= skid_valid ? skid : rec;
    end

    // FIFO pointers, flushed when a new load is accepted
    always_ff @(posedge cl or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (accept) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Load/run sequencer with capture bookkeeping; any stop reason overrides the state step
    always_ff @(posedge cl or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sense_keys <= '0;
            load_cr    <= 1'b0;
            run_en     <= 1'b0;
            stop_code  <= '0;
            inst_count <= '0;
            drops      <= '0;
            timer      <= '0;
            run_cycles <= '0;
            inst_q     <= 1'b0;
            skid_valid <= 1'b0;
            skid       <= '0;
        end else begin
            inst_q     <= inst;
            skid_valid <= skid_next;
            if (to_skid) skid <= rec;
            if (cap) inst_count <= inst_next;
            if (cap && blocked && !to_skid && drops != 16'hFFFF) drops <= drops + 16'd1;
            if (in_run) run_cycles <= run_cycles + 32'd1;
            case (state)
                IDLE, DONE: if (accept) begin
                    state      <= KEYS;
                    sense_keys <= key_mask;
                    run_en     <= 1'b1;
                    stop_code  <= '0;
                    inst_count <= '0;
                    drops      <= '0;
                    timer      <= '0;
                end
                KEYS: if (timer == 32'(KEY_SETTLE - 1)) begin
                    state   <= LOAD;
                    load_cr <= 1'b1;
                    timer   <= '0;
                end else timer <= timer + 32'd1;
                LOAD: if (timer == 32'(LOAD_CYCLES - 1)) begin
                    state      <= RUN;
                    load_cr    <= 1'b0;
                    run_cycles <= '0;
                end else timer <= timer + 32'd1;
                RUN: if (skid_next) begin
                    state  <= HOLD;
                    run_en <= 1'b0;
                end
                HOLD: if (!skid_next) begin
                    state  <= RUN;
                    run_en <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (code != 3'd0) begin
                state      <= DONE;
                sense_keys <= '0;
                load_cr    <= 1'b0;
                run_en     <= 1'b0;
                stop_code  <= code;
            end
        end
    end
endmodule

// File: doc/load_trace_ctl.md
# load_trace_ctl

Synthesizable run controller and instruction-trace recorder for the 704 SYSTEM model. It sequences a card-reader LOAD: sense keys set, LOAD_CR pressed for a programmed time, then released. It gates the system clock enable until a stop condition occurs. On each instruction strobe it captures IC, AC, MQ, the index registers and STG into a trace FIFO that a host drains over a valid/ready port.

## Interface
Parameters:
- NKEYS, 6: number of sense-key outputs.
- NXR, 3: number of index registers traced.
- XR_W, 13: index register width, including the tag/overflow bit.
- IC_W, 13: instruction counter width.
- DEPTH, 16: trace FIFO entries. Must be a power of two, 2 to 256.
- KEY_SETTLE, 4: cycles the keys are held before LOAD_CR asserts. Must be 1 or more.
- LOAD_CYCLES, 1000: cycles LOAD_CR stays asserted. Must be 1 or more.
- MAX_INST, 0: instruction limit. 0 disables it.
- MAX_CYCLES, 0: run-cycle timeout. 0 disables it.
- STOP_ON_FULL, 1: 1 stalls the run when the FIFO is full; 0 drops records.

Ports (REC_W = IC_W+38+36+NXR*XR_W+36):
- CL  in  1  system clock.
- RESET_N  in  1  reset. Asynchronous, active-low.
- START  in  1  one-cycle pulse that begins a load. Accepted only in IDLE or DONE; ignored otherwise.
- ABORT  in  1  forces DONE from any non-IDLE state.
- KEY_MASK  in  NKEYS  sense keys to set. Sampled when START is accepted.
- SENSE_KEYS  out  NKEYS  sense-key drive.
- LOAD_CR  out  1  load-card-reader button drive.
- RUN_EN  out  1  system clock enable.
- PROG_STOP, RD_WR_SELECT, RD_WR_CHECK  in  1 each  status lamps.
- INST  in  1  instruction strobe (I9·D1·not-load). Level input; rising edge is significant.
- IC  in  IC_W;  AC  in  38 (S,Q,P,1..35);  MQ  in  36;  XR  in  NXR*XR_W (XR[0] in the LSBs);  STG  in  36.
- TR_DATA  out  REC_W  record {IC,AC,MQ,XR,STG}, IC in the MSBs.
- TR_VALID  out  1;  TR_READY  in  1  trace read handshake.
- INST_COUNT  out  32  instructions captured or dropped since START.
- DROPS  out  16  dropped records. Saturates at 16'hFFFF.
- STOP_CODE  out  3  stop reason: 0 none, 1 PROG_STOP, 2 RD_WR_CHECK, 3 instruction limit, 4 timeout, 5 abort.
- BUSY  out  1  high in KEYS/LOAD/RUN/HOLD.
- DONE  out  1  high in DONE.

## Operation
- States: IDLE, KEYS, LOAD, RUN, HOLD, DONE.
- IDLE→KEYS on accepted START:
  - SENSE_KEYS<=KEY_MASK; RUN_EN=1.
  - INST_COUNT, DROPS and STOP_CODE clear.
  - FIFO is flushed.
- KEYS→LOAD after KEY_SETTLE cycles. LOAD_CR=1 for exactly LOAD_CYCLES cycles.
- LOAD→RUN: LOAD_CR=0. SENSE_KEYS stay held until DONE.
- Stop test, evaluated in RUN each cycle: stop = !RD_WR_SELECT && (PROG_STOP || RD_WR_CHECK).
  - If both lamps are set, code 2 wins.
  - The instruction limit applies when INST_COUNT reaches MAX_INST (code 3).
  - The timeout applies when RUN+HOLD cycles reach MAX_CYCLES (code 4).
  - Lamps take priority over the limit, and the limit over the timeout.
- Any stop → DONE: RUN_EN=0, SENSE_KEYS=0, STOP_CODE latched.
- ABORT:
  - From KEYS/LOAD/RUN/HOLD it goes to DONE with code 5 and LOAD_CR=0.
  - ABORT in IDLE or DONE is ignored.
- Capture is active in LOAD, RUN and HOLD. A capture event is INST=1 with the previous-cycle INST=0; one record per event.
- FIFO full at a capture:
  - If a pop occurs the same cycle, the push is accepted.
  - Otherwise, STOP_ON_FULL=1: the push is retained in a one-entry skid register and the state goes RUN→HOLD.
  - Otherwise, STOP_ON_FULL=0: the record is dropped and DROPS increments. INST_COUNT still increments.
- HOLD: RUN_EN=0. On the first cycle with a free slot, the skid entry is pushed and the state returns to RUN (RUN_EN=1 next cycle). Stop lamps are not evaluated in HOLD.
- DONE:
  - The FIFO remains readable.
  - A new START is accepted only when the FIFO is empty. A START while the FIFO is non-empty is ignored.
- Reset (including mid-operation): state IDLE, FIFO empty, skid empty. All outputs 0: SENSE_KEYS, LOAD_CR, RUN_EN, TR_VALID, TR_DATA, counters, STOP_CODE, BUSY, DONE. LOAD_CR and SENSE_KEYS drop asynchronously.

## Timing
- Registered outputs; state changes on CL rising edge.
- START at edge n: SENSE_KEYS and BUSY valid after n. LOAD_CR first high after edge n+KEY_SETTLE.
- Stop lamp sampled at edge m: RUN_EN=0 and DONE=1 after edge m, so the system receives no further enabled cycle.
- Capture at edge k into an empty FIFO: TR_VALID=1 after k, with TR_DATA being the values sampled at k.
- A pop occurs on an edge with TR_VALID&&TR_READY. TR_DATA is stable while TR_VALID&&!TR_READY. Sustained throughput is one record per cycle.
- Occupancy wraps modulo DEPTH on the pointers. Full = DEPTH entries.

## Test plan
- KEY_MASK=6'b010100, START → SENSE_KEYS=010100; LOAD_CR high exactly LOAD_CYCLES cycles starting KEY_SETTLE cycles after START; RUN_EN=1 throughout.
- Run to PROG_STOP with RD_WR_SELECT=0 → RUN_EN=0 the same edge; STOP_CODE=1; DONE=1; INST_COUNT equals the strobe count. Repeat with RD_WR_SELECT=1 → no stop.
- 20 strobes, DEPTH=16, TR_READY=0, STOP_ON_FULL=1 → HOLD after the 17th strobe with RUN_EN=0. Drain one → resume. All 20 records are read in order, IC ascending.
- Same with STOP_ON_FULL=0 → DROPS=4; INST_COUNT=20; the 16 oldest records are retained.
- MAX_INST=5 → DONE with STOP_CODE=3 after the 5th capture. With MAX_CYCLES=50 and no strobes → STOP_CODE=4 at cycle 50 of RUN.
- RESET_N low mid-LOAD → LOAD_CR, SENSE_KEYS and RUN_EN=0 immediately; TR_VALID=0. ABORT in RUN → STOP_CODE=5.
